// File: rtl/atm_keypad_entry.sv
// atm_keypad_entry: keypad front-end that turns key strobes into the PIN and
// amount operands for ATM_Top, with clear/cancel/overflow/inactivity handling.
module atm_keypad_entry #(
  parameter int password_width = 4,
  parameter int balance_width  = 20,
  parameter int max_digits     = 6,
  parameter int timeout_cycles = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_pin,
  input  logic                             start_amount,
  input  logic                             key_valid,
  input  logic [3:0]                       key_code,
  output logic [password_width-1:0]        password_input,
  output logic [balance_width-1:0]         value,
  output logic                             pin_valid,
  output logic                             value_valid,
  output logic                             entry_busy,
  output logic [$clog2(max_digits+1)-1:0]  digit_count,
  output logic                             timeout,
  output logic                             overflow_err
);

  localparam int DCW = $clog2(max_digits + 1);
  localparam int TW  = $clog2(timeout_cycles + 1);
  localparam int PW  = balance_width + 4;

  typedef enum logic [1:0] {IDLE, PIN_ENTRY, AMT_ENTRY} state_t;

  state_t                    state_q, state_d;
  logic [balance_width-1:0]  acc_q, acc_d;
  logic [balance_width-1:0]  value_q, value_d;
  logic [password_width-1:0] pwd_q, pwd_d;
  logic [DCW-1:0]            dc_q, dc_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic                      pin_valid_q, pin_valid_d;
  logic                      value_valid_q, value_valid_d;
  logic                      timeout_q, timeout_d;
  logic                      ovf_q, ovf_d;
  logic                      busy_q, busy_d;

  // Widened so acc*10+d never wraps; the top nibble flags an out-of-range amount.
  logic [PW-1:0] prod;
  logic          digit_ok;

  // Next-state, accumulator, timer and pulse computation.
  always_comb begin
    prod          = {4'b0000, acc_q} * PW'(10) + PW'(key_code);
    digit_ok      = (dc_q < DCW'(max_digits)) && (prod[PW-1 -: 4] == 4'b0000);
    state_d       = state_q;
    acc_d         = acc_q;
    value_d       = value_q;
    pwd_d         = pwd_q;
    dc_d          = dc_q;
    timer_d       = timer_q;
    pin_valid_d   = 1'b0;
    value_valid_d = 1'b0;
    timeout_d     = 1'b0;
    ovf_d         = 1'b0;

    if (state_q == IDLE) begin
      timer_d = '0;
      if (start_pin) begin
        state_d = PIN_ENTRY;
        acc_d   = '0;
        dc_d    = '0;
      end else if (start_amount) begin
        state_d = AMT_ENTRY;
        acc_d   = '0;
        dc_d    = '0;
      end
    end else if (key_valid) begin
      timer_d = '0;
      if (key_code <= 4'd9) begin
        if (state_q == PIN_ENTRY) begin
          acc_d = balance_width'(key_code);
          dc_d  = DCW'(1);
        end else if (digit_ok) begin
          acc_d = prod[balance_width-1:0];
          dc_d  = dc_q + DCW'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else begin
        case (key_code)
          4'hA: begin
            if (dc_q != '0) begin
              if (state_q == PIN_ENTRY) begin
                pwd_d       = password_width'(acc_q[3:0]);
                pin_valid_d = 1'b1;
              end else begin
                value_d       = acc_q;
                value_valid_d = 1'b1;
              end
              state_d = IDLE;
              acc_d   = '0;
              dc_d    = '0;
            end
          end
          4'hB: begin
            acc_d = '0;
            dc_d  = '0;
          end
          4'hC: begin
            state_d = IDLE;
            acc_d   = '0;
            dc_d    = '0;
          end
          default: ;
        endcase
      end
    end else if (timer_q == TW'(timeout_cycles - 1)) begin
      // This keyless edge is the Nth in a row: abort the entry.
      timeout_d = 1'b1;
      state_d   = IDLE;
      acc_d     = '0;
      dc_d      = '0;
      timer_d   = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      value_q       <= '0;
      pwd_q         <= '0;
      dc_q          <= '0;
      timer_q       <= '0;
      pin_valid_q   <= 1'b0;
      value_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      ovf_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      value_q       <= value_d;
      pwd_q         <= pwd_d;
      dc_q          <= dc_d;
      timer_q       <= timer_d;
      pin_valid_q   <= pin_valid_d;
      value_valid_q <= value_valid_d;
      timeout_q     <= timeout_d;
      ovf_q         <= ovf_d;
      busy_q        <= busy_d;
    end
  end

  assign password_input = pwd_q;
  assign value          = value_q;
  assign pin_valid      = pin_valid_q;
  assign value_valid    = value_valid_q;
  assign entry_busy     = busy_q;
  assign digit_count    = dc_q;
  assign timeout        = timeout_q;
  assign overflow_err   = ovf_q;

endmodule
